// File: rtl/cw_bubble_stage.sv
// cw_bubble_stage: ID/EX control-word register with multi-cycle hazard bubbles, branch flush, PC/IF-ID hold and saturating bubble count
module cw_bubble_stage #(
  parameter int CW_WIDTH = 17,
  parameter int BRANCH_BIT = 16,
  parameter logic [CW_WIDTH-1:0] NOP_WORD = {CW_WIDTH{1'b0}},
  parameter int STALL_W = 3,
  parameter int BCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CW_WIDTH-1:0] cw_in,
  input  logic                cw_valid_in,
  input  logic                hazard,
  input  logic [STALL_W-1:0]  stall_cycles,
  input  logic                flush,
  output logic [CW_WIDTH-1:0] cw_out,
  output logic                valid_out,
  output logic                ID_branch_instr,
  output logic                hold,
  output logic [BCNT_W-1:0]   bubble_cnt
);
  typedef enum logic {RUN, STALL} state_t;
  localparam logic [STALL_W-1:0] ONE = 1;
  localparam logic [BCNT_W-1:0] BONE = 1;
  state_t state, state_nx;
  logic [STALL_W-1:0] cnt, cnt_nx, n;
  logic in_stall, start, bubble;
  always_comb begin
    in_stall = state == STALL;
    start = ~in_stall & ~flush & hazard;
    n = (stall_cycles == '0) ? ONE : stall_cycles;
    hold = in_stall | start;
    bubble = in_stall | flush | hazard;
    cnt_nx = in_stall ? (flush ? '0 : cnt - ONE) : start ? n - ONE : cnt;
    state_nx = in_stall ? ((flush | (cnt == ONE)) ? RUN : STALL) : (start & (n > ONE)) ? STALL : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      cw_out <= NOP_WORD;
      valid_out <= 1'b0;
      ID_branch_instr <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      cw_out <= bubble ? NOP_WORD : cw_in;
      valid_out <= ~bubble & cw_valid_in;
      ID_branch_instr <= ~bubble & cw_valid_in & cw_in[BRANCH_BIT];
      if (bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + BONE;
    end
  end
endmodule

// File: tb/tb_cw_bubble_stage.sv
// tb_cw_bubble_stage: directed and randomized checks of cw_bubble_stage against a bubble-budget reference model
module tb_cw_bubble_stage;
  localparam int BW = 4;
  localparam int SAT = (1 << BW) - 1;
  logic clk = 0;
  logic reset = 0;
  logic [16:0] cw_in = '0;
  logic cw_valid_in = 0;
  logic hazard = 0;
  logic [2:0] stall_cycles = '0;
  logic flush = 0;
  logic [16:0] cw_out;
  logic valid_out, ID_branch_instr, hold;
  logic [BW-1:0] bubble_cnt;
  int checks = 0;
  int failures = 0;
  logic [16:0] m_cw;
  logic m_valid, m_br;
  int m_cnt, m_left;
  logic hold_seen, exp_hold;

  cw_bubble_stage #(.BCNT_W(BW)) dut (
    .clk(clk), .reset(reset), .cw_in(cw_in), .cw_valid_in(cw_valid_in),
    .hazard(hazard), .stall_cycles(stall_cycles), .flush(flush),
    .cw_out(cw_out), .valid_out(valid_out), .ID_branch_instr(ID_branch_instr),
    .hold(hold), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic do_bubble;
    m_cw = '0;
    m_valid = 0;
    m_br = 0;
    m_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
  endtask

  task automatic tick;
    @(negedge clk);
    hold_seen = hold;
    exp_hold = (m_left > 0) || (!flush && hazard);
    @(posedge clk);
    if (reset) begin
      m_cw = '0;
      m_valid = 0;
      m_br = 0;
      m_cnt = 0;
      m_left = 0;
    end else if (m_left > 0) begin
      do_bubble();
      m_left = flush ? 0 : m_left - 1;
    end else if (flush) begin
      do_bubble();
    end else if (hazard) begin
      do_bubble();
      m_left = ((stall_cycles == 0) ? 1 : int'(stall_cycles)) - 1;
    end else begin
      m_cw = cw_in;
      m_valid = cw_valid_in;
      m_br = cw_in[16] & cw_valid_in;
    end
    #1;
  endtask

  task automatic idle;
    reset = 0;
    hazard = 0;
    flush = 0;
    stall_cycles = '0;
  endtask

  task automatic test_reset;
    reset = 1;
    tick();
    checks++;
    if (cw_out !== 17'h0 || valid_out !== 0 || ID_branch_instr !== 0 || bubble_cnt !== '0) begin
      failures++;
      $display("FAIL reset: cw=%h v=%b br=%b cnt=%0d, required 0 0 0 0", cw_out, valid_out, ID_branch_instr, bubble_cnt);
    end
    reset = 0;
  endtask

  task automatic test_pass;
    idle();
    cw_in = 17'h1_0005;
    cw_valid_in = 1;
    tick();
    checks++;
    if (cw_out !== 17'h1_0005 || valid_out !== 1 || ID_branch_instr !== 1 || hold_seen !== 0) begin
      failures++;
      $display("FAIL pass: cw=%h v=%b br=%b hold=%b, required 10005 1 1 0", cw_out, valid_out, ID_branch_instr, hold_seen);
    end
  endtask

  task automatic test_single_bubble;
    cw_in = 17'h00123;
    hazard = 1;
    stall_cycles = 0;
    tick();
    checks++;
    if (hold_seen !== 1 || cw_out !== 17'h0 || valid_out !== 0 || bubble_cnt !== BW'(1)) begin
      failures++;
      $display("FAIL single_bubble: hold=%b cw=%h v=%b cnt=%0d, required 1 0 0 1", hold_seen, cw_out, valid_out, bubble_cnt);
    end
    hazard = 0;
    tick();
    checks++;
    if (hold_seen !== 0 || cw_out !== 17'h00123 || valid_out !== 1 || bubble_cnt !== BW'(1)) begin
      failures++;
      $display("FAIL single_release: hold=%b cw=%h v=%b cnt=%0d, required 0 00123 1 1", hold_seen, cw_out, valid_out, bubble_cnt);
    end
  endtask

  task automatic test_multi_stall;
    int holds = 0;
    int nops = 0;
    cw_in = 17'h0_0abc;
    cw_valid_in = 1;
    hazard = 1;
    stall_cycles = 3;
    for (int i = 0; i < 6; i++) begin
      hazard = (i == 0) || (i == 1);
      stall_cycles = (i == 1) ? 3'd7 : 3'd3;
      tick();
      holds += hold_seen;
      nops += (valid_out === 0);
      checks++;
      if (cw_out !== m_cw || hold_seen !== exp_hold) begin
        failures++;
        $display("FAIL multi_stall[%0d]: cw=%h hold=%b, required %h %b", i, cw_out, hold_seen, m_cw, exp_hold);
      end
    end
    checks++;
    if (holds != 3 || nops != 3 || bubble_cnt !== BW'(4)) begin
      failures++;
      $display("FAIL multi_stall_total: holds=%0d nops=%0d cnt=%0d, required 3 3 4", holds, nops, bubble_cnt);
    end
  endtask

  task automatic test_flush;
    idle();
    cw_in = 17'h1_0777;
    cw_valid_in = 1;
    flush = 1;
    hazard = 1;
    stall_cycles = 4;
    tick();
    checks++;
    if (hold_seen !== 0 || cw_out !== 17'h0 || valid_out !== 0 || ID_branch_instr !== 0) begin
      failures++;
      $display("FAIL flush_run: hold=%b cw=%h v=%b br=%b, required 0 0 0 0", hold_seen, cw_out, valid_out, ID_branch_instr);
    end
    idle();
    tick();
    checks++;
    if (hold_seen !== 0 || cw_out !== 17'h1_0777 || ID_branch_instr !== 1) begin
      failures++;
      $display("FAIL flush_run_next: hold=%b cw=%h br=%b, required 0 10777 1", hold_seen, cw_out, ID_branch_instr);
    end
    cw_in = 17'h0_0042;
    hazard = 1;
    stall_cycles = 5;
    tick();
    hazard = 0;
    flush = 1;
    tick();
    checks++;
    if (hold_seen !== 1 || valid_out !== 0) begin
      failures++;
      $display("FAIL flush_stall: hold=%b v=%b, required 1 0", hold_seen, valid_out);
    end
    flush = 0;
    tick();
    checks++;
    if (hold_seen !== 0 || cw_out !== 17'h0_0042 || valid_out !== 1) begin
      failures++;
      $display("FAIL flush_stall_next: hold=%b cw=%h v=%b, required 0 00042 1", hold_seen, cw_out, valid_out);
    end
  endtask

  task automatic test_reset_mid_stall;
    idle();
    cw_in = 17'h1_1111;
    hazard = 1;
    stall_cycles = 7;
    tick();
    hazard = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    checks++;
    if (hold !== 0 || cw_out !== 17'h0 || valid_out !== 0 || ID_branch_instr !== 0 || bubble_cnt !== '0) begin
      failures++;
      $display("FAIL reset_mid_stall: hold=%b cw=%h v=%b br=%b cnt=%0d, required 0 0 0 0 0", hold, cw_out, valid_out, ID_branch_instr, bubble_cnt);
    end
    tick();
    checks++;
    if (cw_out !== 17'h1_1111 || valid_out !== 1) begin
      failures++;
      $display("FAIL reset_mid_stall_pass: cw=%h v=%b, required 11111 1", cw_out, valid_out);
    end
  endtask

  task automatic test_saturation;
    idle();
    for (int i = 0; i < 20; i++) begin
      hazard = 1;
      stall_cycles = 0;
      tick();
    end
    checks++;
    if (bubble_cnt !== 4'hF) begin
      failures++;
      $display("FAIL saturation: cnt=%0d, required 15", bubble_cnt);
    end
    hazard = 0;
    tick();
    checks++;
    if (bubble_cnt !== 4'hF || valid_out !== cw_valid_in) begin
      failures++;
      $display("FAIL saturation_hold: cnt=%0d v=%b, required 15 %b", bubble_cnt, valid_out, cw_valid_in);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      hazard = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 9) < 1);
      stall_cycles = 3'($urandom_range(0, 7));
      cw_in = 17'($urandom);
      cw_valid_in = $urandom_range(0, 1);
      tick();
      checks++;
      if (hold_seen !== exp_hold || cw_out !== m_cw || valid_out !== m_valid ||
          ID_branch_instr !== m_br || bubble_cnt !== BW'(m_cnt) || (ID_branch_instr & ~valid_out)) begin
        failures++;
        $display("FAIL random[%0d]: hold=%b cw=%h v=%b br=%b cnt=%0d, required %b %h %b %b %0d",
                 i, hold_seen, cw_out, valid_out, ID_branch_instr, bubble_cnt, exp_hold, m_cw, m_valid, m_br, m_cnt);
      end
    end
  endtask

  initial begin
    m_cw = '0;
    m_valid = 0;
    m_br = 0;
    m_cnt = 0;
    m_left = 0;
    test_reset();
    test_pass();
    test_single_bubble();
    test_multi_stall();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
